// File: rtl/gcd_job_sequencer.sv
// Feeder/collector for the ee354_GCD engine: buffers operand pairs, sequences
// Start/Done/Ack, bypasses zero operands and aborts hung jobs via a watchdog.
module gcd_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       step_en,
  input  logic       gcd_idle,
  input  logic       gcd_done,
  input  logic [7:0] gcd_result,
  output logic [7:0] gcd_ain,
  output logic [7:0] gcd_bin,
  output logic       gcd_start,
  output logic       gcd_ack,
  output logic       gcd_cen,
  output logic       eng_rst,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_a,
  output logic [7:0] res_b,
  output logic [7:0] res_gcd,
  output logic       res_err,
  output logic       busy,
  output logic [7:0] jobs_done
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    ACK       = 3'd3,
    EMIT      = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   wdog;
  logic [7:0]    head_a, head_b;
  logic          empty, push, pop, head_zero, timeout_hit, res_take;

  assign empty       = (count == {(AW+1){1'b0}});
  assign in_ready    = (count != FULL_CNT);
  assign push        = in_valid && in_ready;
  assign pop         = (state == IDLE) && !empty && gcd_idle;
  assign {head_a, head_b} = mem[rd_ptr];
  assign head_zero   = (head_a == 8'd0) || (head_b == 8'd0);
  // done wins over the watchdog when both land in the same cycle
  assign timeout_hit = (state == WAIT_DONE) && !gcd_done && step_en && (wdog == WDOG_LAST);
  assign res_take    = (state == EMIT) && res_ready;

  assign gcd_start = (state == ISSUE);
  assign gcd_ack   = (state == ACK);
  assign res_valid = (state == EMIT);
  assign gcd_cen   = step_en;
  assign busy      = (state != IDLE) || !empty;

  // operand storage
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pop) state_nxt = head_zero ? EMIT : ISSUE;
        else     state_nxt = IDLE;
      end
      ISSUE: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (gcd_done)         state_nxt = ACK;
        else if (timeout_hit) state_nxt = EMIT;
        else                  state_nxt = WAIT_DONE;
      end
      ACK: begin
        if (gcd_idle) state_nxt = EMIT;
        else          state_nxt = ACK;
      end
      EMIT: begin
        if (res_ready) state_nxt = IDLE;
        else           state_nxt = EMIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // job datapath: operands, result capture, watchdog, completion counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gcd_ain   <= 8'd0;
      gcd_bin   <= 8'd0;
      res_a     <= 8'd0;
      res_b     <= 8'd0;
      res_gcd   <= 8'd0;
      res_err   <= 1'b0;
      eng_rst   <= 1'b0;
      wdog      <= 16'd0;
      jobs_done <= 8'd0;
    end else begin
      eng_rst <= timeout_hit;
      case (state)
        IDLE: begin
          if (pop) begin
            res_a   <= head_a;
            res_b   <= head_b;
            res_err <= 1'b0;
            if (head_zero) begin
              res_gcd <= head_a | head_b;
            end else begin
              gcd_ain <= head_a;
              gcd_bin <= head_b;
            end
          end
        end
        ISSUE: wdog <= 16'd0;
        WAIT_DONE: begin
          if (gcd_done) begin
            res_gcd <= gcd_result;
          end else if (timeout_hit) begin
            res_gcd <= 8'd0;
            res_err <= 1'b1;
          end else if (step_en) begin
            wdog <= wdog + 16'd1;
          end
        end
        default: wdog <= wdog;
      endcase
      if (res_take) jobs_done <= jobs_done + 8'd1;
    end
  end
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Randomised self-checking bench for gcd_job_sequencer with a behavioural
// GCD engine model and a queue-based expectation of result order.
module tb_gcd_job_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       in_valid, in_ready, step_en, res_ready;
  logic [7:0] in_a, in_b;
  logic       gcd_idle, gcd_done, gcd_start, gcd_ack, gcd_cen, eng_rst;
  logic [7:0] gcd_result, gcd_ain, gcd_bin;
  logic       res_valid, res_err, busy;
  logic [7:0] res_a, res_b, res_gcd, jobs_done;

  int checks = 0, errors = 0, accepted = 0, start_cnt = 0;
  bit eng_hang = 1'b0;

  logic [1:0] eng_st;
  int         eng_cnt;
  logic [7:0] eng_res;

  always #5 Clk = ~Clk;

  gcd_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .step_en(step_en), .gcd_idle(gcd_idle),
    .gcd_done(gcd_done), .gcd_result(gcd_result), .gcd_ain(gcd_ain),
    .gcd_bin(gcd_bin), .gcd_start(gcd_start), .gcd_ack(gcd_ack),
    .gcd_cen(gcd_cen), .eng_rst(eng_rst), .res_valid(res_valid),
    .res_ready(res_ready), .res_a(res_a), .res_b(res_b), .res_gcd(res_gcd),
    .res_err(res_err), .busy(busy), .jobs_done(jobs_done)
  );

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    int x = a, y = b, t;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return 8'(x);
  endfunction

  function automatic int eng_latency(input logic [7:0] a, input logic [7:0] b);
    return 1 + ((a ^ b) % 8);
  endfunction

  // Engine model: Start/Ack always seen, computation advances only with CEN
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      eng_st <= 2'd0; eng_cnt <= 0; eng_res <= 8'd0;
    end else if (eng_rst) begin
      eng_st <= 2'd0;
    end else begin
      case (eng_st)
        2'd0: if (gcd_start) begin
          eng_st  <= 2'd1;
          eng_cnt <= eng_latency(gcd_ain, gcd_bin);
          eng_res <= ref_gcd(gcd_ain, gcd_bin);
        end
        2'd1: if (gcd_cen && !eng_hang) begin
          if (eng_cnt <= 1) eng_st <= 2'd2;
          else              eng_cnt <= eng_cnt - 1;
        end
        2'd2: if (gcd_ack) eng_st <= 2'd0;
        default: eng_st <= 2'd0;
      endcase
    end
  end

  assign gcd_idle   = (eng_st == 2'd0);
  assign gcd_done   = (eng_st == 2'd2);
  assign gcd_result = eng_res;

  always @(negedge Clk) if (gcd_start) start_cnt <= start_cnt + 1;

  task automatic push(input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok = 1'b0; in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge Clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic get_result(input int budget, output logic [7:0] a, output logic [7:0] b,
                            output logic [7:0] g, output logic e, output bit got);
    got = 1'b0; a = 8'd0; b = 8'd0; g = 8'd0; e = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (res_valid) begin
        a = res_a; b = res_b; g = res_gcd; e = res_err; got = 1'b1; accepted++;
        @(negedge Clk);
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (res_valid !== 1'b0 || gcd_start !== 1'b0 || eng_rst !== 1'b0) begin
      errors++; $display("FAIL rst_ctrl got valid=%b start=%b eng_rst=%b exp 0", res_valid, gcd_start, eng_rst); end
    checks++; if ({res_a, res_b, res_gcd, gcd_ain, gcd_bin, jobs_done} !== 48'd0 || res_err !== 1'b0) begin
      errors++; $display("FAIL rst_data got a=%0d b=%0d g=%0d jobs=%0d exp 0", res_a, res_b, res_gcd, jobs_done); end
    Reset = 1'b0;
    @(negedge Clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_release got in_ready=%b busy=%b exp 1/0", in_ready, busy); end
  endtask

  task automatic test_basic();
    logic [7:0] a, b, g; logic e; bit got, ok; int s0;
    s0 = start_cnt; res_ready = 1'b1; step_en = 1'b1;
    push(8'd36, 8'd24, ok);
    get_result(200, a, b, g, e, got);
    checks++; if (!ok || !got) begin errors++; $display("FAIL basic_handshake got push=%b res=%b exp 1/1", ok, got); end
    checks++; if (g !== 8'd12) begin errors++; $display("FAIL basic_gcd got %0d exp 12", g); end
    checks++; if (a !== 8'd36 || b !== 8'd24 || e !== 1'b0) begin
      errors++; $display("FAIL basic_fields got a=%0d b=%0d err=%b exp 36/24/0", a, b, e); end
    checks++; if (jobs_done !== 8'd1) begin errors++; $display("FAIL basic_jobs got %0d exp 1", jobs_done); end
    checks++; if (start_cnt != s0 + 1) begin errors++; $display("FAIL basic_start_pulses got %0d exp 1", start_cnt - s0); end
  endtask

  task automatic test_bypass();
    logic [7:0] pa [2] = '{8'd0, 8'd17};
    logic [7:0] pb [2] = '{8'd45, 8'd0};
    bit ok; int s0;
    s0 = start_cnt; res_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push(pa[k], pb[k], ok);
      @(negedge Clk);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bypass_latency%0d got valid=%b exp 1", k, res_valid); end
      checks++; if (res_gcd !== (pa[k] | pb[k]) || res_a !== pa[k] || res_b !== pb[k] || res_err !== 1'b0) begin
        errors++; $display("FAIL bypass_result%0d got g=%0d a=%0d b=%0d exp g=%0d", k, res_gcd, res_a, res_b, pa[k] | pb[k]); end
      accepted++;
      @(negedge Clk);
      checks++; if (jobs_done !== 8'(accepted)) begin errors++; $display("FAIL bypass_jobs%0d got %0d exp %0d", k, jobs_done, accepted); end
    end
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL bypass_no_start got %0d pulses exp 0", start_cnt - s0); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, g, ea, eb; logic e; bit got, ok;
    for (int k = 0; k < 10; k++) begin
      ea = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      eb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      push(ea, eb, ok);
      get_result(200, a, b, g, e, got);
      checks++; if (!got || a !== ea || b !== eb || g !== ref_gcd(ea, eb) || e !== 1'b0) begin
        errors++; $display("FAIL random%0d got a=%0d b=%0d g=%0d err=%b exp a=%0d b=%0d g=%0d", k, a, b, g, e, ea, eb, ref_gcd(ea, eb)); end
    end
    checks++; if (jobs_done !== 8'(accepted)) begin errors++; $display("FAIL random_jobs got %0d exp %0d", jobs_done, accepted); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [7:0] a, b, g, ea, eb; logic e; bit got; int acc = 0; logic last_ready = 1'b1;
    res_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ea = 8'($urandom_range(1, 255)); eb = 8'($urandom_range(0, 255));
      in_a = ea; in_b = eb; in_valid = 1'b1; last_ready = in_ready;
      if (in_ready) begin exp_q.push_back({ea, eb}); acc++; end
      @(negedge Clk);
    end
    in_valid = 1'b0;
    checks++; if (acc != 5) begin errors++; $display("FAIL b2b_accepted got %0d exp 5", acc); end
    checks++; if (last_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", last_ready); end
    while (exp_q.size() > 0) begin
      {ea, eb} = exp_q.pop_front();
      get_result(300, a, b, g, e, got);
      checks++; if (!got || a !== ea || b !== eb || g !== ref_gcd(ea, eb)) begin
        errors++; $display("FAIL b2b_order got a=%0d b=%0d g=%0d exp a=%0d b=%0d g=%0d", a, b, g, ea, eb, ref_gcd(ea, eb)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drained got busy=%b exp 0", busy); end
  endtask

  task automatic test_timeout();
    bit ok, seen = 1'b0; int n = 0;
    res_ready = 1'b1; step_en = 1'b1; eng_hang = 1'b1;
    push(8'd20, 8'd30, ok);
    for (int i = 0; i < 50; i++) begin
      if (gcd_start) begin seen = 1'b1; break; end
      @(negedge Clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL tmo_start got no start exp pulse"); end
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk); n++;
      if (eng_rst) break;
    end
    checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL tmo_cycles got %0d exp %0d", n, TIMEOUT + 1); end
    checks++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_gcd !== 8'd0 || res_a !== 8'd20 || res_b !== 8'd30) begin
      errors++; $display("FAIL tmo_result got v=%b err=%b g=%0d a=%0d b=%0d exp 1/1/0/20/30", res_valid, res_err, res_gcd, res_a, res_b); end
    accepted++;
    @(negedge Clk);
    checks++; if (eng_rst !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse got eng_rst=%b valid=%b exp 0/0", eng_rst, res_valid); end
    checks++; if (jobs_done !== 8'(accepted)) begin errors++; $display("FAIL tmo_jobs got %0d exp %0d", jobs_done, accepted); end
    eng_hang = 1'b0;
  endtask

  task automatic test_reset_midjob();
    bit ok, seen = 1'b0; int s0, stray = 0;
    step_en = 1'b0; res_ready = 1'b1;
    push(8'd200, 8'd150, ok);
    for (int i = 0; i < 50; i++) begin
      if (gcd_start) begin seen = 1'b1; break; end
      @(negedge Clk);
    end
    for (int k = 0; k < 3; k++) push(8'(k + 3), 8'(k + 9), ok);
    checks++; if (!seen || busy !== 1'b1) begin errors++; $display("FAIL rmid_setup got start=%b busy=%b exp 1/1", seen, busy); end
    Reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || gcd_ack !== 1'b0 || eng_rst !== 1'b0) begin
      errors++; $display("FAIL rmid_ctrl got in_ready=%b busy=%b valid=%b ack=%b exp 1/0/0/0", in_ready, busy, res_valid, gcd_ack); end
    checks++; if ({res_a, res_b, res_gcd, gcd_ain, gcd_bin, jobs_done} !== 48'd0 || res_err !== 1'b0) begin
      errors++; $display("FAIL rmid_data got a=%0d b=%0d g=%0d ain=%0d jobs=%0d exp 0", res_a, res_b, res_gcd, gcd_ain, jobs_done); end
    @(negedge Clk);
    Reset = 1'b0; accepted = 0; step_en = 1'b1; s0 = start_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (res_valid || busy) stray++;
    end
    checks++; if (stray != 0 || start_cnt != s0) begin
      errors++; $display("FAIL rmid_stale got %0d active cycles %0d starts exp 0/0", stray, start_cnt - s0); end
  endtask

  task automatic test_step_toggle_wrap();
    logic [7:0] a, b, g, eb; logic e; bit got = 1'b0, ok; int guard = 0;
    res_ready = 1'b1; step_en = 1'b1;
    push(8'd255, 8'd85, ok);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge Clk);
      step_en = ~step_en;
      if (res_valid) begin g = res_gcd; e = res_err; got = 1'b1; accepted++; end
    end
    @(negedge Clk);
    step_en = 1'b1;
    checks++; if (!got || g !== 8'd85 || e !== 1'b0) begin
      errors++; $display("FAIL toggle_result got valid=%b g=%0d err=%b exp 1/85/0", got, g, e); end
    while (accepted < 256 && guard < 300) begin
      guard++;
      eb = 8'($urandom_range(1, 255));
      push(8'd0, eb, ok);
      get_result(50, a, b, g, e, got);
      checks++; if (!got || g !== eb) begin errors++; $display("FAIL wrap_job got g=%0d exp %0d", g, eb); end
      if (accepted == 255) begin
        checks++; if (jobs_done !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", jobs_done); end
      end
    end
    checks++; if (accepted != 256 || jobs_done !== 8'd0) begin
      errors++; $display("FAIL wrap_zero got %0d after %0d jobs exp 0 after 256", jobs_done, accepted); end
  endtask

  initial begin
    Reset = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0;
    step_en = 1'b1; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_bypass();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_midjob();
    test_step_toggle_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
